// File: rtl/load_store_unit.sv
// Load/store unit: runs one load or store per instruction on a request/response data bus,
// returning lane-extracted load data and single-cycle completion/fault pulses.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TIMEOUT_W      = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic [31:0] wb_mask,
    output logic        done,
    output logic        misaligned,
    output logic        access_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                 state, next_state;
    logic                   op_we;
    logic [2:0]             op_funct3;
    logic [1:0]             op_off;
    logic [TIMEOUT_W-1:0]   timer;
    logic                   bad_req, rsp_done, timeout_hit, timer_expired;
    logic                   sel_we;
    logic [2:0]             sel_funct3;
    logic [1:0]             sel_off;

    // Unsupported funct3 encodings are folded into the alignment fault.
    function automatic logic is_bad(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: is_bad = 1'b0;
            3'b001, 3'b101: is_bad = off[0];
            3'b010:         is_bad = (off != 2'b00);
            default:        is_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [35:0] store_lanes(input logic we, input logic [2:0] f3,
                                                input logic [1:0] off, input logic [31:0] wdata);
        logic [31:0] data;
        logic [3:0]  strb;
        case (f3[1:0])
            2'b00: begin
                data = {4{wdata[7:0]}};
                strb = 4'b0001 << off;
            end
            2'b01: begin
                data = {2{wdata[15:0]}};
                strb = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                data = wdata;
                strb = 4'b1111;
            end
        endcase
        if (!we) strb = 4'b0000;
        store_lanes = {data, strb};
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        b  = 8'(word >> {off, 3'b000});
        h  = off[1] ? word[31:16] : word[15:0];
        sb = b;
        sh = h;
        case (f3)
            3'b000:  load_extract = 32'(sb);
            3'b001:  load_extract = 32'(sh);
            3'b100:  load_extract = {24'h0, b};
            3'b101:  load_extract = {16'h0, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] load_mask(input logic [2:0] f3);
        case (f3)
            3'b100:  load_mask = 32'h0000_00FF;
            3'b101:  load_mask = 32'h0000_FFFF;
            default: load_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    assign timer_expired = (TIMEOUT_CYCLES != 0) && (timer == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign bus_req_valid = (state == REQ);

    // A misaligned op finishes straight from IDLE, so its attributes come from the request itself.
    assign sel_we     = (state == IDLE) ? req_we : op_we;
    assign sel_funct3 = (state == IDLE) ? req_funct3 : op_funct3;
    assign sel_off    = (state == IDLE) ? req_addr[1:0] : op_off;

    always_comb begin
        next_state  = state;
        bad_req     = is_bad(req_funct3, req_addr[1:0]);
        rsp_done    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: if (req_valid) next_state = bad_req ? DONE : REQ;
            REQ: begin
                if (bus_req_ready && bus_rsp_valid) begin
                    rsp_done   = 1'b1;
                    next_state = DONE;
                end else if (timer_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end else if (bus_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus_rsp_valid) begin
                    rsp_done   = 1'b1;
                    next_state = DONE;
                end else if (timer_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_we        <= 1'b0;
            op_funct3    <= 3'b000;
            op_off       <= 2'b00;
            timer        <= '0;
            bus_addr     <= 32'h0;
            bus_we       <= 1'b0;
            bus_wdata    <= 32'h0;
            bus_wstrb    <= 4'h0;
            read_data    <= 32'h0;
            read_valid   <= 1'b0;
            wb_mask      <= 32'hFFFF_FFFF;
            done         <= 1'b0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            if (state == IDLE && req_valid && !bad_req) begin
                op_we                  <= req_we;
                op_funct3              <= req_funct3;
                op_off                 <= req_addr[1:0];
                timer                  <= '0;
                bus_addr               <= {req_addr[31:2], 2'b00};
                bus_we                 <= req_we;
                {bus_wdata, bus_wstrb} <= store_lanes(req_we, req_funct3, req_addr[1:0], req_wdata);
            end else if (state == REQ || state == WAIT) begin
                timer <= timer + 1'b1;
            end
            done         <= (next_state == DONE);
            read_valid   <= (next_state == DONE) && !sel_we;
            misaligned   <= (state == IDLE) && req_valid && bad_req;
            access_fault <= timeout_hit;
            if (next_state == DONE && !sel_we) begin
                read_data <= rsp_done ? load_extract(bus_rdata, sel_funct3, sel_off) : 32'h0;
                wb_mask   <= load_mask(sel_funct3);
            end
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side counterpart of the core's write-back path. Takes one load or store request per instruction from execute and runs it on the data bus (request/response handshake).
- For loads, returns lane-aligned, sign/zero-extended data with read_valid and wb_mask. Write-back consumes these directly: it stalls while read_valid is low and masks with wb_mask.
- Detects misaligned accesses and bus timeouts and reports them as single-cycle fault pulses.

Parameters:
- TIMEOUT_CYCLES, 256, max cycles spent in REQ+WAIT before access_fault; 0 disables the timeout.
- TIMEOUT_W, 9, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  execute presents a memory op; held stable until done
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address (ALU result)
- req_wdata  input  32  store data (rs2, unshifted)
- bus_req_valid  output  1  bus request valid
- bus_req_ready  input  1  bus accepts request
- bus_addr  output  32  word-aligned address ({req_addr[31:2],2'b00})
- bus_we  output  1  write enable
- bus_wdata  output  32  store data shifted to byte lane
- bus_wstrb  output  4  byte strobes
- bus_rsp_valid  input  1  response beat (read data, or write ack)
- bus_rdata  input  32  raw word from bus
- read_data  output  32  extracted load data (shifted to bit 0, sign-extended for B/H)
- read_valid  output  1  load result valid this cycle
- wb_mask  output  32  0x000000FF for BU, 0x0000FFFF for HU, 0xFFFFFFFF otherwise
- done  output  1  op complete (load or store), single cycle
- misaligned  output  1  alignment fault pulse, coincident with done
- access_fault  output  1  timeout fault pulse, coincident with done

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE. All bus_* outputs 0. read_data=0, read_valid=0, done=0, misaligned=0, access_fault=0, wb_mask=0xFFFFFFFF. Timeout counter=0. Reset mid-access abandons the op; any late bus_rsp_valid is ignored while in IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid=1:
  - Misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> DONE with misaligned=1, no bus request.
  - Otherwise latch addr, we, funct3 and lane-shifted wdata/wstrb -> REQ.
- REQ: bus_req_valid=1, bus_* stable. bus_req_ready=1 -> WAIT. bus_rsp_valid in the same cycle as ready is legal; go straight to DONE and capture the data.
- WAIT: bus_req_valid=0. bus_rsp_valid=1 -> capture bus_rdata, go to DONE.
- Timeout: counter increments every cycle in REQ/WAIT and clears on entering REQ. When it reaches TIMEOUT_CYCLES (nonzero) -> DONE with access_fault=1, read_data=0, bus_req_valid dropped.
- DONE: one cycle, then IDLE. done=1; read_valid=1 only if the op is a load. Outputs are registered, so they are valid in the DONE cycle.
  - Upstream advances in this cycle and presents a new or deasserted req_valid next cycle.
  - Fastest accesses: load/store latency from req_valid sample to done is 2 cycles (IDLE->REQ->DONE). A misaligned op takes 1 cycle to DONE.
- Store lanes:
  - B: wdata replicated per byte, wstrb=1<<addr[1:0].
  - H: wdata[15:0] in both halves, wstrb=0011 or 1100 per addr[1].
  - W: wstrb=1111.
  - Loads: wstrb=0000.
- Load extract:
  - Select byte lane addr[1:0] or half lane addr[1].
  - B/H sign-extend; BU/HU zero-extend and set wb_mask as above.
  - W passes the word through.
  - On a fault, read_data=0.
- Unsupported funct3 (011, 110, 111): treated as misaligned (fault, no bus access).
- read_data/wb_mask hold their last values outside DONE; only read_valid/done qualify them.

Test Plan:
- LBU addr 0x1003, bus_rdata 0xA1B2C3D4, ready and rsp after 1 cycle each -> read_data 0x000000A1, wb_mask 0x000000FF, read_valid=1 for exactly 1 cycle, bus_addr 0x1000.
- LH addr 0x2002, rdata 0x8001_7FFF -> read_data 0xFFFF8001, wb_mask 0xFFFFFFFF.
- SB addr 0x3001, wdata 0x000000EE -> bus_wdata 0xEEEEEEEE, wstrb 0010, bus_we=1; after ack, done=1, read_valid=0.
- LW addr 0x4002 -> no bus_req_valid ever; misaligned=1 and done=1 one cycle after req.
- TIMEOUT_CYCLES=4, bus_req_ready held 0 -> access_fault=1 with done in the 5th cycle after entering REQ, bus_req_valid low afterward.
- rst asserted while in WAIT, then bus_rsp_valid pulses -> outputs at reset values, no read_valid; next LW 0x5000 completes normally.
